// File: rtl/bvudiv_bvslt_eval.sv
// Sequential restoring divider (one quotient bit per cycle) feeding a registered
// signed less-than predicate. Optional remainder output under BVUDIV_REM_OUT_EN.
module bvudiv_bvslt_eval #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] q,
  output logic         lt,
  output logic         busy
`ifdef BVUDIV_REM_OUT_EN
  ,output logic [W-1:0] r
`endif
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, b_q, c_q, rem_q;
  logic [W-2:0]  quo_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  q_q;
  logic          lt_q;
`ifdef BVUDIV_REM_OUT_EN
  logic [W-1:0]  r_q;
`endif

  // b == 0 needs no special path: every compare succeeds, quotient bits all
  // set and nothing is subtracted, so the remainder ends up equal to a.
  logic [W:0]   rem_sh;
  logic         ge;
  logic [W-1:0] rem_nx, quo_nx;
  logic         lt_nx;

  always_comb begin
    rem_sh = {rem_q, a_q[W-1]};
    ge     = rem_sh >= {1'b0, b_q};
    rem_nx = ge ? (rem_sh[W-1:0] - b_q) : rem_sh[W-1:0];
    quo_nx = {quo_q, ge};
    lt_nx  = $signed(quo_nx) < $signed(c_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)      state_d = DIV;
      DIV:     if (cnt_q == '0)   state_d = DONE;
      DONE:    if (out_ready)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      q_q   <= '0;
      lt_q  <= 1'b0;
`ifdef BVUDIV_REM_OUT_EN
      r_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= b;
          c_q   <= c;
          rem_q <= '0;
          quo_q <= '0;
          cnt_q <= CW'(W-1);
        end
        DIV: begin
          a_q   <= {a_q[W-2:0], 1'b0};
          rem_q <= rem_nx;
          quo_q <= quo_nx[W-2:0];
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            q_q  <= quo_nx;
            lt_q <= lt_nx;
`ifdef BVUDIV_REM_OUT_EN
            r_q  <= rem_nx;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign q         = q_q;
  assign lt        = lt_q;
`ifdef BVUDIV_REM_OUT_EN
  assign r         = r_q;
`endif

endmodule

// File: tb/tb_bvudiv_bvslt_eval.sv
// Directed vector table, stall/reset sequences and an exhaustive W=4 sweep
// against an SMT-LIB bvudiv/bvurem/bvslt reference.
module tb_bvudiv_bvslt_eval;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0, c = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] q;
  logic         lt;
  logic         busy;
`ifdef BVUDIV_REM_OUT_EN
  logic [W-1:0] r;
`endif

  int total = 0;
  int bad   = 0;

  bvudiv_bvslt_eval #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .lt(lt), .busy(busy)
`ifdef BVUDIV_REM_OUT_EN
    , .r(r)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b, c, q;
    logic         lt;
    logic [W-1:0] r;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: SMT-LIB division by zero gives all-ones quotient, remainder a.
  task automatic ref_model(input logic [W-1:0] ra, rb, rc,
                           output logic [W-1:0] rq, output logic rlt,
                           output logic [W-1:0] rr);
    if (rb == 0) begin
      rq = '1;
      rr = ra;
    end else begin
      rq = ra / rb;
      rr = ra % rb;
    end
    rlt = $signed(rq) < $signed(rc);
  endtask

  // Offer a triple, check acceptance and latency, then compare the result.
  // Leaves the DUT in DONE with out_ready low.
  task automatic issue(input logic [W-1:0] ta, tb, tc);
    int n;
    @(negedge clk);
    chk("in_ready_before_issue", int'(in_ready), 1);
    a = ta; b = tb; c = tc; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      chk("busy_in_div", int'(busy), 1);
      @(negedge clk);
      n++;
    end
    chk("latency_edges_after_accept", n, W);
  endtask

  task automatic result_chk(input string tag, input logic [W-1:0] eq,
                            input logic elt, input logic [W-1:0] er);
    chk({tag, "_q"}, int'(q), int'(eq));
    chk({tag, "_lt"}, int'(lt), int'(elt));
`ifdef BVUDIV_REM_OUT_EN
    chk({tag, "_r"}, int'(r), int'(er));
`else
    if (er != er) chk({tag, "_r"}, 0, 1);
`endif
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_handshake", int'(out_valid), 0);
    chk("in_ready_after_handshake", int'(in_ready), 1);
  endtask

  initial begin
    logic [W-1:0] mq, mr;
    logic         mlt;

    //        a      b      c      q      lt    r
    tv[0] = '{4'd9,  4'd2,  4'd5,  4'd4,  1'b1, 4'd1};
    tv[1] = '{4'd6,  4'd0,  4'd0,  4'd15, 1'b1, 4'd6};
    tv[2] = '{4'd7,  4'd3,  4'd8,  4'd2,  1'b0, 4'd1};
    tv[3] = '{4'd15, 4'd1,  4'd0,  4'd15, 1'b1, 4'd0};
    tv[4] = '{4'd0,  4'd5,  4'd0,  4'd0,  1'b0, 4'd0};
    tv[5] = '{4'd15, 4'd15, 4'd7,  4'd1,  1'b1, 4'd0};
    tv[6] = '{4'd12, 4'd5,  4'd15, 4'd2,  1'b0, 4'd2};
    tv[7] = '{4'd0,  4'd0,  4'd8,  4'd15, 1'b0, 4'd0};

    // Reset state
    #2;
    chk("rst_q", int'(q), 0);
    chk("rst_lt", int'(lt), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      issue(tv[i].a, tv[i].b, tv[i].c);
      result_chk($sformatf("vec%0d", i), tv[i].q, tv[i].lt, tv[i].r);
      handshake();
      chk($sformatf("vec%0d_q_held_idle", i), int'(q), int'(tv[i].q));
    end

    // Stall in DONE with a competing triple offered
    issue(4'd9, 4'd2, 4'd5);
    a = 4'd3; b = 4'd1; c = 4'd0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_q", int'(q), 4);
      chk("stall_lt", int'(lt), 1);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall_release_in_ready", int'(in_ready), 1);
    chk("stall_release_out_valid", int'(out_valid), 0);
    chk("stall_release_q_held", int'(q), 4);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("stall_next_accepted", int'(busy), 1);
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    result_chk("stall_next", 4'd3, 1'b0, 4'd0);
    handshake();

    // Reset during the second DIV cycle
    @(negedge clk);
    a = 4'd9; b = 4'd2; c = 4'd5; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_q", int'(q), 0);
    chk("abort_lt", int'(lt), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("abort_no_result", seen, 0);
    end
    issue(4'd15, 4'd1, 4'd0);
    result_chk("post_abort", 4'd15, 1'b1, 4'd0);
    handshake();

    // Exhaustive sweep
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 16; ic++) begin
          ref_model(W'(ia), W'(ib), W'(ic), mq, mlt, mr);
          issue(W'(ia), W'(ib), W'(ic));
          result_chk($sformatf("sweep_a%0d_b%0d_c%0d", ia, ib, ic), mq, mlt, mr);
          handshake();
        end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
